// File: rtl/palette_ram.sv
// Writable colour palette for the VGA pixel path: index -> RGB with a two-stage
// pipelined lookup, per-lookup dimming and optional transparent-index detection.
module palette_ram #(
  parameter int IDX_W      = 4,
  parameter int NUM_COLORS = 16,
  parameter int COLOR_W    = 24,
  parameter bit TRANSP_EN  = 1'b1,
  parameter int TRANSP_IDX = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               rd_valid,
  input  logic [IDX_W-1:0]   colorIdx,
  input  logic [1:0]         dim,
  output logic [COLOR_W-1:0] rgbVal,
  output logic               rgb_valid,
  output logic               transparent
);

  localparam int CH_W  = COLOR_W / 3;
  localparam int DEPTH = 2 ** IDX_W;

  function automatic logic [23:0] defaultRgb24(input int i);
    case (i)
      0:       return 24'hB0B0B0;
      1:       return 24'h0E490A;
      2:       return 24'h1A8512;
      3:       return 24'h21D113;
      4:       return 24'h0F3D82;
      5:       return 24'h1C70EE;
      6:       return 24'h75A6F0;
      7:       return 24'h801313;
      8:       return 24'hE60E0E;
      9:       return 24'hE66868;
      default: return 24'h000000;
    endcase
  endfunction

  // 8-bit channels are left-aligned into CH_W-bit fields: zero-padded when
  // wider, LSB-truncated when narrower.
  function automatic logic [COLOR_W-1:0] defaultColor(input int i);
    logic [23:0]        rgb24;
    logic [CH_W+7:0]    wide;
    logic [COLOR_W-1:0] res;
    rgb24 = defaultRgb24(i);
    res   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      wide = {rgb24[ch*8 +: 8], {CH_W{1'b0}}};
      res[ch*CH_W +: CH_W] = wide[CH_W+7 -: CH_W];
    end
    if (i >= NUM_COLORS) res = '0;
    return res;
  endfunction

  function automatic logic [COLOR_W-1:0] dimColor(input logic [COLOR_W-1:0] c,
                                                  input logic [1:0]         d);
    logic [COLOR_W-1:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++)
      res[ch*CH_W +: CH_W] = c[ch*CH_W +: CH_W] >> d;
    return res;
  endfunction

  logic [DEPTH-1:0][COLOR_W-1:0] palette;
  logic                          wrHit;
  logic                          rdHit;
  logic                          transpHit;

  assign wrHit     = (32'(wr_idx) < 32'(NUM_COLORS));
  assign rdHit     = (32'(colorIdx) < 32'(NUM_COLORS));
  assign transpHit = TRANSP_EN && (32'(colorIdx) == 32'(TRANSP_IDX));

  for (genvar g = 0; g < DEPTH; g++) begin : gEntry
    logic [COLOR_W-1:0] entry;
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
        entry <= defaultColor(g);
      else if (wr_en && wrHit && (wr_idx == IDX_W'(g)))
        entry <= wr_data;
    end
    assign palette[g] = entry;
  end

  logic               vld_p1;
  logic [COLOR_W-1:0] col_p1;
  logic               transp_p1;
  logic [1:0]         dim_p1;

  // Stage 1: table read with pre-edge contents (same-edge write is not bypassed)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1    <= 1'b0;
      col_p1    <= '0;
      transp_p1 <= 1'b0;
      dim_p1    <= 2'd0;
    end else begin
      vld_p1    <= rd_valid;
      col_p1    <= rdHit ? palette[colorIdx] : '0;
      transp_p1 <= transpHit;
      dim_p1    <= dim;
    end
  end

  // Stage 2: dimming, transparency and output qualification
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_valid   <= 1'b0;
      transparent <= 1'b0;
      rgbVal      <= '0;
    end else begin
      rgb_valid   <= vld_p1;
      transparent <= vld_p1 & transp_p1;
      rgbVal      <= (!vld_p1 || transp_p1) ? '0 : dimColor(col_p1, dim_p1);
    end
  end

endmodule

// File: tb/tb_palette_ram.sv
// Scoreboard bench for palette_ram: default instance plus a NUM_COLORS=12,
// TRANSP_EN=0 instance, both driven by the same stimulus.
module tb_palette_ram;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [23:0] wr_data;
  logic        rd_valid;
  logic [3:0]  colorIdx;
  logic [1:0]  dim;

  logic [23:0] rgbValA, rgbValB;
  logic        rgb_validA, rgb_validB;
  logic        transparentA, transparentB;

  always #5 Clk = ~Clk;

  palette_ram dutA (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_valid(rd_valid), .colorIdx(colorIdx), .dim(dim),
    .rgbVal(rgbValA), .rgb_valid(rgb_validA), .transparent(transparentA)
  );

  palette_ram #(.NUM_COLORS(12), .TRANSP_EN(1'b0)) dutB (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_valid(rd_valid), .colorIdx(colorIdx), .dim(dim),
    .rgbVal(rgbValB), .rgb_valid(rgb_validB), .transparent(transparentB)
  );

  typedef struct packed {
    logic        v;
    logic        t;
    logic [23:0] rgb;
  } exp_t;

  localparam logic [23:0] DEF [10] = '{
    24'hB0B0B0, 24'h0E490A, 24'h1A8512, 24'h21D113, 24'h0F3D82,
    24'h1C70EE, 24'h75A6F0, 24'h801313, 24'hE60E0E, 24'hE66868
  };

  exp_t        qA[$];
  exp_t        qB[$];
  logic [23:0] memA [16];
  logic [23:0] memB [16];
  int          checks = 0;
  int          failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic loadDefaults();
    for (int i = 0; i < 16; i++) begin
      memA[i] = (i < 10) ? DEF[i] : 24'h0;
      memB[i] = (i < 10) ? DEF[i] : 24'h0;
    end
  endtask

  function automatic exp_t model(input logic v, input logic [3:0] idx, input logic [1:0] d,
                                 input logic [23:0] entry, input logic inRange, input logic tEn);
    exp_t        e;
    logic [7:0]  r, g, b;
    logic [23:0] c;
    c   = inRange ? entry : 24'h0;
    r   = c[23:16] >> d;
    g   = c[15:8] >> d;
    b   = c[7:0] >> d;
    e.v = v;
    e.t = v && tEn && (idx == 4'd0);
    e.rgb = (v && !e.t) ? {r, g, b} : 24'h0;
    return e;
  endfunction

  task automatic checkOut();
    exp_t ea, eb;
    if (qA.size() >= 2) begin
      ea = qA.pop_front();
      eb = qB.pop_front();
      checkVal("A.valid",  32'(rgb_validA),   32'(ea.v));
      checkVal("A.transp", 32'(transparentA), 32'(ea.t));
      checkVal("A.rgb",    32'(rgbValA),      32'(ea.rgb));
      checkVal("B.valid",  32'(rgb_validB),   32'(eb.v));
      checkVal("B.transp", 32'(transparentB), 32'(eb.t));
      checkVal("B.rgb",    32'(rgbValB),      32'(eb.rgb));
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] idx, input logic [1:0] d,
                       input logic we, input logic [3:0] widx, input logic [23:0] wd);
    @(negedge Clk);
    checkOut();
    rd_valid = v; colorIdx = idx; dim = d;
    wr_en = we; wr_idx = widx; wr_data = wd;
    qA.push_back(model(v, idx, d, memA[idx], 1'b1, 1'b1));
    qB.push_back(model(v, idx, d, memB[idx], idx < 4'd12, 1'b0));
    if (we) begin
      memA[widx] = wd;
      if (widx < 4'd12) memB[widx] = wd;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 24'h0);
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, ".A.valid"},  32'(rgb_validA),   32'd0);
    checkVal({tag, ".A.transp"}, 32'(transparentA), 32'd0);
    checkVal({tag, ".A.rgb"},    32'(rgbValA),      32'd0);
    checkVal({tag, ".B.valid"},  32'(rgb_validB),   32'd0);
    checkVal({tag, ".B.rgb"},    32'(rgbValB),      32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    rd_valid = 1'b0; colorIdx = '0; dim = '0;
    loadDefaults();
    #12;
    checkZero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Full table sweep, dim=0
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 2'd0, 1'b0, 4'd0, 24'h0);
    idle(); idle();

    // Write then next-edge read; same-edge write/read hazard
    cycle(1'b0, 4'd0, 2'd0, 1'b1, 4'd10, 24'h123456);
    cycle(1'b1, 4'd10, 2'd0, 1'b0, 4'd0, 24'h0);
    cycle(1'b1, 4'd3, 2'd0, 1'b1, 4'd3, 24'h00FF00);
    cycle(1'b1, 4'd3, 2'd0, 1'b0, 4'd0, 24'h0);

    // Dim sweep on a saturated entry
    for (int d = 0; d < 4; d++) cycle(1'b1, 4'd8, 2'(d), 1'b0, 4'd0, 24'h0);

    // Out-of-range write on the 12-entry instance, then index 0 on both
    cycle(1'b0, 4'd0, 2'd0, 1'b1, 4'd14, 24'hABCDEF);
    cycle(1'b1, 4'd14, 2'd0, 1'b0, 4'd0, 24'h0);
    cycle(1'b1, 4'd0, 2'd0, 1'b0, 4'd0, 24'h0);
    cycle(1'b1, 4'd0, 2'd2, 1'b0, 4'd0, 24'h0);
    idle(); idle();

    // Asynchronous reset with lookups in flight and a committed write
    cycle(1'b1, 4'd1, 2'd0, 1'b1, 4'd5, 24'hFFFFFF);
    cycle(1'b1, 4'd2, 2'd0, 1'b0, 4'd0, 24'h0);
    #1 Reset = 1'b1;
    #1 checkZero("midReset");
    qA.delete();
    qB.delete();
    loadDefaults();
    wr_en = 1'b1; wr_idx = 4'd5; wr_data = 24'hFFFFFF;
    repeat (2) begin
      @(negedge Clk);
      checkZero("heldReset");
    end
    Reset = 1'b0;
    wr_en = 1'b0;
    rd_valid = 1'b0;
    cycle(1'b1, 4'd5, 2'd0, 1'b0, 4'd0, 24'h0);
    idle(); idle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)), 24'($urandom));
    end
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
